// File: rtl/gcd_unit_pkg.sv
// Shared definitions for the GCD engine: state encoding and default operand width.
package gcd_unit_pkg;

    localparam int unsigned DefaultWidth = 8;

    // 2'd3 is unreachable; the FSM decode sends it back to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmp  = 2'd1,
        StDone = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator producing one-hot equal/greater/less flags.
module comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             is_equal,
    output logic             is_great,
    output logic             is_less
);

    assign is_equal = (a == b);
    assign is_great = (a > b);
    assign is_less  = (a < b);

endmodule

// File: rtl/gcd_unit.sv
// Subtractive GCD engine: start/ready handshake, one compare-driven step per cycle.
module gcd_unit
    import gcd_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             is_equal, is_great, is_less;
    logic             any_zero;

    comparator #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .a       (ra_q),
        .b       (rb_q),
        .is_equal(is_equal),
        .is_great(is_great),
        .is_less (is_less)
    );

    assign any_zero = (ra_q == '0) || (rb_q == '0);

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    ra_d    = a_in;
                    rb_d    = b_in;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                // Zero check outranks the flags so gcd(0,x)=x and gcd(0,0)=0.
                if (any_zero) begin
                    result_d = ra_q | rb_q;
                    state_d  = StDone;
                end else if (is_equal) begin
                    result_d = ra_q;
                    state_d  = StDone;
                end else if (is_great) begin
                    ra_d = ra_q - rb_q;
                end else if (is_less) begin
                    rb_d = rb_q - ra_q;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ra_q     <= '0;
            rb_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            result_q <= result_d;
        end
    end

    assign ready  = (state_q == StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Directed self-checking bench for gcd_unit at WIDTH=8.
module tb_gcd_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       ready;
    logic       done;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    gcd_unit #(
        .WIDTH(8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .ready (ready),
        .done  (done),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept one operation from IDLE, count edges until done, check latency and result.
    // poke_at >= 0 drives a spurious start with (6,4) on that edge count.
    task automatic run(input logic [7:0] a, input logic [7:0] b, input int exp_edges,
                       input logic [7:0] exp_res, input logic [7:0] old_res,
                       input int poke_at, input string tag);
        int n;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " ready_low"}, {31'd0, ready}, 32'd0);
        chk({tag, " result_held"}, {24'd0, result}, {24'd0, old_res});
        n = 0;
        while (!done && n < 1000) begin
            if (n == poke_at) begin
                start = 1'b1;
                a_in  = 8'd6;
                b_in  = 8'd4;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        chk({tag, " edges_to_done"}, n, exp_edges);
        chk({tag, " result"}, {24'd0, result}, {24'd0, exp_res});
        @(posedge clk);
        #1;
        chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, " ready_after"}, {31'd0, ready}, 32'd1);
        chk({tag, " result_kept"}, {24'd0, result}, {24'd0, exp_res});
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = 8'd0;
        b_in  = 8'd0;
        #12;
        chk("rst ready", {31'd0, ready}, 32'd1);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst result", {24'd0, result}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("idle ready", {31'd0, ready}, 32'd1);
            chk("idle done", {31'd0, done}, 32'd0);
        end
        chk("idle result", {24'd0, result}, 32'd0);

        // 12,8 -> 4,8 -> 4,4: k=2, done after 3 edges
        run(8'd12, 8'd8, 3, 8'd4, 8'd0, -1, "g12_8");
        run(8'd7, 8'd7, 1, 8'd7, 8'd4, -1, "g7_7");
        run(8'd0, 8'd9, 1, 8'd9, 8'd7, -1, "g0_9");
        run(8'd0, 8'd0, 1, 8'd0, 8'd9, -1, "g0_0");
        run(8'd9, 8'd0, 1, 8'd9, 8'd0, -1, "g9_0");
        // k=254 steps, spurious start four edges in must be ignored
        run(8'd255, 8'd1, 255, 8'd1, 8'd9, 4, "g255_1");

        // Reset mid-computation
        a_in  = 8'd48;
        b_in  = 8'd18;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst ready", {31'd0, ready}, 32'd1);
        chk("midrst result", {24'd0, result}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("midrst no_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b0;
        // 48,18 -> 30,18 -> 12,18 -> 12,6 -> 6,6: k=4
        run(8'd48, 8'd18, 5, 8'd6, 8'd0, -1, "g48_18");

        // Continuous start: 9,6 -> 3,6 -> 3,3, a result every 5 cycles
        a_in  = 8'd9;
        b_in  = 8'd6;
        start = 1'b1;
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("cont first_done", {31'd0, done}, 32'd1);
        chk("cont first_result", {24'd0, result}, 32'd3);
        for (int p = 0; p < 3; p++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!done && n < 50);
            chk("cont period", n, 32'd5);
            chk("cont result", {24'd0, result}, 32'd3);
        end
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("final ready", {31'd0, ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
